// File: rtl/lsu_mmio_split_if.sv
// Request/response bus between the core pipeline and the load/store unit.
//   master : drives req, wren, size, is_unsigned, addr, st_data
//   slave  : returns busy, done, err, ld_data
//   size   : 00 byte, 01 half, 10 word, 11 reserved
//   ld_data: load result, valid with done and held until the next done
interface lsu_mmio_split_if;
    logic        req;
    logic        wren;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [15:0] addr;
    logic [31:0] st_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ld_data;

    modport master (
        output req, wren, size, is_unsigned, addr, st_data,
        input  busy, done, err, ld_data
    );

    modport slave (
        input  req, wren, size, is_unsigned, addr, st_data,
        output busy, done, err, ld_data
    );
endinterface

// File: rtl/lsu_mmio_split.sv
// Load/store unit for the RV32I core: data memory plus memory-mapped IO.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : request/response interface (slave side)
//   i_io_sw/btn    : raw switch/button pins, synchronised internally
//   o_io_ledr/ledg/lcd : 32-bit output registers
//   o_io_hex       : 7-segment digits, digit k at [7k+6:7k]
// Accesses crossing a DMEM word boundary take two cycles (o_busy for one).
module lsu_mmio_split #(
    parameter int DMEM_WORDS  = 2048,
    parameter int NUM_HEX     = 8,
    parameter int SW_W        = 32,
    parameter int BTN_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    lsu_mmio_split_if.slave      bus,
    input  logic [SW_W-1:0]      i_io_sw,
    input  logic [BTN_W-1:0]     i_io_btn,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [31:0]          o_io_lcd,
    output logic [7*NUM_HEX-1:0] o_io_hex
);
    localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [15:0] LEDR_A = 16'h7000;
    localparam logic [15:0] LEDG_A = 16'h7010;
    localparam logic [15:0] HEX_A  = 16'h7020;
    localparam logic [15:0] LCD_A  = 16'h7030;
    localparam logic [15:0] SW_A   = 16'h7800;
    localparam logic [15:0] BTN_A  = 16'h7810;

    typedef enum logic [0:0] {IDLE, SPLIT} state_t;
    state_t state_q, state_d;

    function automatic logic [31:0] fmt_load(input logic [63:0] pair, input logic [1:0] sh,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] w;
        w = 32'(pair >> {sh, 3'b000});
        case (sz)
            2'b00:   fmt_load = uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   fmt_load = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: fmt_load = w;
        endcase
    endfunction

    logic [31:0] ledr_q, ledg_q, lcd_q;
    logic [6:0]  hex_q [8];
    logic [SW_W-1:0]  sw_sync  [SYNC_STAGES];
    logic [BTN_W-1:0] btn_sync [SYNC_STAGES];
    logic [31:0] mem [DMEM_WORDS];

    // Request decode (stage p0: combinational on the presented request)
    logic [1:0]  ofs;
    logic [3:0]  be_base;
    logic [7:0]  be64;
    logic [63:0] wd64;
    logic [AW-1:0] widx;
    logic is_dmem, last_word, crosses, io_misalign, split_req, err_req, accept, go;
    logic is_ledr, is_ledg, is_hex, is_lcd, is_sw, is_btn, is_io, is_in;

    assign ofs = bus.addr[1:0];
    always_comb begin
        case (bus.size)
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            2'b10:   be_base = 4'b1111;
            default: be_base = 4'b0000;
        endcase
    end
    // Lanes beyond bit 3 of be64/wd64 belong to the following word.
    assign be64 = {4'b0000, be_base} << ofs;
    assign wd64 = {32'h0, bus.st_data} << {ofs, 3'b000};
    assign widx = bus.addr[AW+1:2];

    assign is_dmem   = {16'h0, bus.addr} < 32'(4 * DMEM_WORDS);
    assign last_word = (32'(widx) + 32'd1) >= 32'(DMEM_WORDS);
    assign crosses   = |be64[7:4];
    assign is_ledr   = bus.addr[15:2] == LEDR_A[15:2];
    assign is_ledg   = bus.addr[15:2] == LEDG_A[15:2];
    assign is_hex    = bus.addr[15:3] == HEX_A[15:3];
    assign is_lcd    = bus.addr[15:2] == LCD_A[15:2];
    assign is_sw     = bus.addr[15:2] == SW_A[15:2];
    assign is_btn    = bus.addr[15:2] == BTN_A[15:2];
    assign is_in     = is_sw | is_btn;
    assign is_io     = is_ledr | is_ledg | is_hex | is_lcd | is_in;
    assign io_misalign = (bus.size == 2'b01 && ofs[0]) || (bus.size == 2'b10 && ofs != 2'b00);

    assign err_req   = (bus.size == 2'b11) || !(is_dmem || is_io) || (is_in && bus.wren)
                     || (!is_dmem && is_io && io_misalign) || (is_dmem && crosses && last_word);
    assign split_req = is_dmem && crosses;
    assign accept    = (state_q == IDLE) && bus.req && i_rst_n;
    assign go        = accept && !err_req;

    // IO read mux; digits beyond NUM_HEX read as zero.
    logic [7:0]  hv [8];
    logic [31:0] hex_word, io_rdata;
    logic [7:0]  hex_we;
    logic [6:0]  hex_wd [8];
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            hv[k]     = (k < NUM_HEX) ? {1'b0, hex_q[k]} : 8'h00;
            hex_we[k] = go && bus.wren && is_hex && (k < NUM_HEX)
                        && (bus.addr[2] == (k >= 4)) && be64[k % 4];
            hex_wd[k] = wd64[8*(k % 4) +: 7];
        end
    end
    assign hex_word = bus.addr[2] ? {hv[7], hv[6], hv[5], hv[4]} : {hv[3], hv[2], hv[1], hv[0]};

    always_comb begin
        io_rdata = 32'h0;
        if (is_ledr)      io_rdata = ledr_q;
        else if (is_ledg) io_rdata = ledg_q;
        else if (is_lcd)  io_rdata = lcd_q;
        else if (is_hex)  io_rdata = hex_word;
        else if (is_sw)   io_rdata = 32'(sw_sync[SYNC_STAGES-1]);
        else if (is_btn)  io_rdata = 32'(btn_sync[SYNC_STAGES-1]);
    end

    // FSM
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        case (state_q)
            IDLE:    if (go && split_req) state_d = SPLIT;
            SPLIT:   begin bus.busy = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
    end

    // Split context captured at accept, consumed in SPLIT
    logic [AW-1:0] sp_idx_p0;
    logic [3:0]    sp_be_p0;
    logic [31:0]   sp_wd_p0, sp_lo_p0;
    logic          sp_wren_p0, sp_uns_p0;
    logic [1:0]    sp_ofs_p0, sp_size_p0;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    // One read port: second word of a split in SPLIT, otherwise the request word.
    assign rd_idx  = (state_q == SPLIT) ? sp_idx_p0 : widx;
    assign rd_word = mem[rd_idx];

    // The second-word write is dropped if reset arrives mid-split.
    always_ff @(posedge i_clk) begin
        if (state_q == SPLIT) begin
            if (i_rst_n && sp_wren_p0)
                for (int b = 0; b < 4; b++)
                    if (sp_be_p0[b]) mem[sp_idx_p0][8*b +: 8] <= sp_wd_p0[8*b +: 8];
        end else if (go && is_dmem && bus.wren) begin
            for (int b = 0; b < 4; b++)
                if (be64[b]) mem[widx][8*b +: 8] <= wd64[8*b +: 8];
        end
    end

    // ---- stage p1: registered load result ----
    logic [31:0] lo_p1, hi_p1;
    logic [1:0]  ofs_p1, size_p1;
    logic        uns_p1, vld_p1, err_p1, ld_zero_p1;

    always_ff @(posedge i_clk) begin
        if (state_q == SPLIT) begin
            lo_p1   <= sp_lo_p0;
            hi_p1   <= rd_word;
            ofs_p1  <= sp_ofs_p0;
            size_p1 <= sp_size_p0;
            uns_p1  <= sp_uns_p0;
        end else if (go) begin
            if (split_req) begin
                sp_idx_p0  <= widx + 1'b1;
                sp_be_p0   <= be64[7:4];
                sp_wd_p0   <= wd64[63:32];
                sp_wren_p0 <= bus.wren;
                sp_lo_p0   <= rd_word;
                sp_ofs_p0  <= ofs;
                sp_size_p0 <= bus.size;
                sp_uns_p0  <= bus.is_unsigned;
            end else begin
                lo_p1   <= is_dmem ? rd_word : io_rdata;
                ofs_p1  <= ofs;
                size_p1 <= bus.size;
                uns_p1  <= bus.is_unsigned;
            end
        end
    end

    // ld_zero_p1 forces o_ld_data to 0 after reset, stores and errors.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
            ld_zero_p1 <= 1'b1;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            if (state_q == SPLIT) begin
                vld_p1     <= 1'b1;
                ld_zero_p1 <= sp_wren_p0;
            end else if (accept) begin
                if (err_req) begin
                    vld_p1     <= 1'b1;
                    err_p1     <= 1'b1;
                    ld_zero_p1 <= 1'b1;
                end else if (!split_req) begin
                    vld_p1     <= 1'b1;
                    ld_zero_p1 <= bus.wren;
                end
            end
        end
    end

    assign bus.done    = vld_p1;
    assign bus.err     = err_p1;
    assign bus.ld_data = ld_zero_p1 ? 32'h0 : fmt_load({hi_p1, lo_p1}, ofs_p1, size_p1, uns_p1);

    // IO registers and input synchronisers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ledr_q <= 32'h0;
            ledg_q <= 32'h0;
            lcd_q  <= 32'h0;
            for (int k = 0; k < 8; k++) hex_q[k] <= 7'h7F;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i]  <= '0;
                btn_sync[i] <= '0;
            end
        end else begin
            sw_sync[0]  <= i_io_sw;
            btn_sync[0] <= i_io_btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i]  <= sw_sync[i-1];
                btn_sync[i] <= btn_sync[i-1];
            end
            for (int b = 0; b < 4; b++) begin
                if (go && bus.wren && be64[b]) begin
                    if (is_ledr) ledr_q[8*b +: 8] <= wd64[8*b +: 8];
                    if (is_ledg) ledg_q[8*b +: 8] <= wd64[8*b +: 8];
                    if (is_lcd)  lcd_q[8*b +: 8]  <= wd64[8*b +: 8];
                end
            end
            for (int k = 0; k < 8; k++)
                if (hex_we[k]) hex_q[k] <= hex_wd[k];
        end
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign o_io_hex[7*k +: 7] = hex_q[k];
    end
endmodule

// File: tb/tb_lsu_mmio_split.sv
module tb_lsu_mmio_split;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [31:0] ledr, ledg, lcd;
    logic [55:0] hex;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    lsu_mmio_split_if bus();

    lsu_mmio_split #(
        .DMEM_WORDS(2048), .NUM_HEX(8), .SW_W(32), .BTN_W(4), .SYNC_STAGES(2)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus),
        .i_io_sw(io_sw), .i_io_btn(io_btn),
        .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_lcd(lcd), .o_io_hex(hex)
    );

    // Issue one request and wait (bounded) for its completion pulse.
    task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] d,
                          output logic dn, output logic er, output logic [31:0] q,
                          output int lat, output logic bsy);
        @(negedge i_clk);
        bus.req = 1'b1; bus.wren = wr; bus.size = sz; bus.is_unsigned = uns;
        bus.addr = a; bus.st_data = d;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req = 1'b0;
        lat = 1; bsy = 1'b0;
        while (bus.done !== 1'b1 && lat < 5) begin
            if (bus.busy === 1'b1) bsy = 1'b1;
            @(negedge i_clk);
            lat++;
        end
        dn = bus.done; er = bus.err; q = bus.ld_data;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_assert++; if (ledr !== 32'h0) begin n_fail++; $display("FAIL rst_ledr: got %h want 0", ledr); end
        n_assert++; if (ledg !== 32'h0) begin n_fail++; $display("FAIL rst_ledg: got %h want 0", ledg); end
        n_assert++; if (lcd !== 32'h0) begin n_fail++; $display("FAIL rst_lcd: got %h want 0", lcd); end
        n_assert++; if (hex !== {8{7'h7F}}) begin n_fail++; $display("FAIL rst_hex: got %h want %h", hex, {8{7'h7F}}); end
        n_assert++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL rst_ctrl: busy=%b done=%b err=%b want 0/0/0", bus.busy, bus.done, bus.err); end
        n_assert++; if (bus.ld_data !== 32'h0) begin n_fail++; $display("FAIL rst_lddata: got %h want 0", bus.ld_data); end
        i_rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        logic dn, er, bsy; logic [31:0] q; int lat;
        access(1'b1, 2'b10, 1'b0, 16'h0100, 32'hDEADBEEF, dn, er, q, lat, bsy);
        n_assert++; if (!(dn === 1'b1 && er === 1'b0 && bsy === 1'b0 && lat == 1)) begin
            n_fail++; $display("FAIL sw_timing: done=%b err=%b busy=%b lat=%0d want 1/0/0/1", dn, er, bsy, lat); end
        access(1'b0, 2'b00, 1'b0, 16'h0103, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb: got %h want FFFFFFDE", q); end
        n_assert++; if (!(dn === 1'b1 && er === 1'b0 && bsy === 1'b0 && lat == 1)) begin
            n_fail++; $display("FAIL lb_timing: done=%b err=%b busy=%b lat=%0d want 1/0/0/1", dn, er, bsy, lat); end
        access(1'b0, 2'b00, 1'b1, 16'h0103, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h000000DE) begin n_fail++; $display("FAIL lbu: got %h want 000000DE", q); end
        access(1'b0, 2'b01, 1'b0, 16'h0102, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL lh: got %h want FFFFDEAD", q); end
        n_assert++; if (!(dn === 1'b1 && bsy === 1'b0 && lat == 1)) begin
            n_fail++; $display("FAIL lh_timing: done=%b busy=%b lat=%0d want 1/0/1", dn, bsy, lat); end
        access(1'b0, 2'b01, 1'b1, 16'h0100, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu: got %h want 0000BEEF", q); end
        access(1'b0, 2'b10, 1'b1, 16'h0100, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw: got %h want DEADBEEF", q); end
    endtask

    task automatic test_back_to_back();
        @(negedge i_clk);
        bus.req = 1'b1; bus.wren = 1'b1; bus.size = 2'b10; bus.is_unsigned = 1'b0;
        bus.addr = 16'h0200; bus.st_data = 32'h12345678;
        @(posedge i_clk);
        @(negedge i_clk);
        n_assert++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_store: done=%b busy=%b want 1/0", bus.done, bus.busy); end
        bus.wren = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req = 1'b0;
        n_assert++; if (bus.done !== 1'b1 || bus.ld_data !== 32'h12345678) begin
            n_fail++; $display("FAIL b2b_load: done=%b data=%h want 1/12345678", bus.done, bus.ld_data); end
    endtask

    task automatic test_misaligned();
        logic dn, er, bsy; logic [31:0] q; int lat;
        access(1'b1, 2'b10, 1'b0, 16'h0004, 32'h0, dn, er, q, lat, bsy);
        access(1'b1, 2'b10, 1'b0, 16'h0008, 32'h0, dn, er, q, lat, bsy);
        access(1'b1, 2'b10, 1'b0, 16'h0006, 32'h11223344, dn, er, q, lat, bsy);
        n_assert++; if (!(dn === 1'b1 && er === 1'b0 && bsy === 1'b1 && lat == 2)) begin
            n_fail++; $display("FAIL split_st_timing: done=%b err=%b busy=%b lat=%0d want 1/0/1/2", dn, er, bsy, lat); end
        access(1'b0, 2'b10, 1'b0, 16'h0004, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h33440000) begin n_fail++; $display("FAIL split_lo_word: got %h want 33440000", q); end
        access(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h00001122) begin n_fail++; $display("FAIL split_hi_word: got %h want 00001122", q); end
        access(1'b0, 2'b10, 1'b0, 16'h0006, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h11223344 || lat != 2 || bsy !== 1'b1) begin
            n_fail++; $display("FAIL split_lw: data=%h lat=%0d busy=%b want 11223344/2/1", q, lat, bsy); end
        access(1'b0, 2'b01, 1'b0, 16'h0007, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h00002233 || lat != 2) begin
            n_fail++; $display("FAIL split_lh: data=%h lat=%0d want 00002233/2", q, lat); end
    endtask

    task automatic test_io();
        logic dn, er, bsy; logic [31:0] q; int lat;
        access(1'b1, 2'b00, 1'b0, 16'h7022, 32'h0000005A, dn, er, q, lat, bsy);
        n_assert++; if (hex[20:14] !== 7'h5A || hex[13:7] !== 7'h7F) begin
            n_fail++; $display("FAIL hex2_write: hex2=%h hex1=%h want 5A/7F", hex[20:14], hex[13:7]); end
        access(1'b0, 2'b10, 1'b0, 16'h7020, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h7F5A7F7F) begin n_fail++; $display("FAIL hex_lw: got %h want 7F5A7F7F", q); end
        access(1'b1, 2'b00, 1'b0, 16'h7023, 32'h000000DA, dn, er, q, lat, bsy);
        access(1'b0, 2'b00, 1'b1, 16'h7023, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h0000005A || hex[27:21] !== 7'h5A) begin
            n_fail++; $display("FAIL hex_bit7: read=%h hex3=%h want 0000005A/5A", q, hex[27:21]); end
        access(1'b0, 2'b10, 1'b0, 16'h7024, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h7F7F7F7F) begin n_fail++; $display("FAIL hex_hi_lw: got %h want 7F7F7F7F", q); end
        access(1'b1, 2'b01, 1'b0, 16'h7012, 32'h0000BEEF, dn, er, q, lat, bsy);
        n_assert++; if (ledg !== 32'hBEEF0000) begin n_fail++; $display("FAIL ledg_sh: got %h want BEEF0000", ledg); end
        access(1'b1, 2'b10, 1'b0, 16'h7000, 32'hCAFEF00D, dn, er, q, lat, bsy);
        n_assert++; if (ledr !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ledr_sw: got %h want CAFEF00D", ledr); end
        access(1'b0, 2'b01, 1'b0, 16'h7002, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'hFFFFCAFE) begin n_fail++; $display("FAIL ledr_lh: got %h want FFFFCAFE", q); end
        access(1'b1, 2'b00, 1'b0, 16'h7031, 32'h000000AB, dn, er, q, lat, bsy);
        n_assert++; if (lcd !== 32'h0000AB00) begin n_fail++; $display("FAIL lcd_sb: got %h want 0000AB00", lcd); end
    endtask

    task automatic test_sync();
        logic dn, er, bsy; logic [31:0] q; int lat;
        @(negedge i_clk);
        io_sw = 32'h0000ABCD;
        bus.req = 1'b1; bus.wren = 1'b0; bus.size = 2'b10; bus.is_unsigned = 1'b0; bus.addr = 16'h7800;
        @(posedge i_clk);
        @(negedge i_clk);
        n_assert++; if (bus.ld_data !== 32'h0) begin n_fail++; $display("FAIL sync_c1: got %h want 0", bus.ld_data); end
        @(posedge i_clk);
        @(negedge i_clk);
        n_assert++; if (bus.ld_data !== 32'h0) begin n_fail++; $display("FAIL sync_c2: got %h want 0", bus.ld_data); end
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req = 1'b0;
        n_assert++; if (bus.ld_data !== 32'h0000ABCD) begin n_fail++; $display("FAIL sync_c3: got %h want 0000ABCD", bus.ld_data); end
        io_btn = 4'hA;
        repeat (3) @(negedge i_clk);
        access(1'b0, 2'b10, 1'b0, 16'h7810, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h0000000A) begin n_fail++; $display("FAIL btn_lw: got %h want 0000000A", q); end
    endtask

    task automatic test_errors();
        logic dn, er, bsy; logic [31:0] q; int lat;
        access(1'b1, 2'b10, 1'b0, 16'h7800, 32'h12345678, dn, er, q, lat, bsy);
        n_assert++; if (!(dn === 1'b1 && er === 1'b1 && lat == 1 && q === 32'h0)) begin
            n_fail++; $display("FAIL err_sw_store: done=%b err=%b lat=%0d data=%h want 1/1/1/0", dn, er, lat, q); end
        access(1'b0, 2'b10, 1'b0, 16'h7800, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h0000ABCD || er !== 1'b0) begin
            n_fail++; $display("FAIL err_sw_unchanged: data=%h err=%b want 0000ABCD/0", q, er); end
        access(1'b1, 2'b10, 1'b0, 16'h1FFC, 32'h55555555, dn, er, q, lat, bsy);
        access(1'b1, 2'b10, 1'b0, 16'h1FFE, 32'hFFFFFFFF, dn, er, q, lat, bsy);
        n_assert++; if (dn !== 1'b1 || er !== 1'b1 || bsy !== 1'b0) begin
            n_fail++; $display("FAIL err_edge_store: done=%b err=%b busy=%b want 1/1/0", dn, er, bsy); end
        access(1'b0, 2'b10, 1'b0, 16'h1FFC, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h55555555) begin n_fail++; $display("FAIL err_edge_unchanged: got %h want 55555555", q); end
        access(1'b0, 2'b10, 1'b0, 16'h7002, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (!(dn === 1'b1 && er === 1'b1 && q === 32'h0)) begin
            n_fail++; $display("FAIL err_io_misalign: done=%b err=%b data=%h want 1/1/0", dn, er, q); end
        access(1'b0, 2'b10, 1'b0, 16'h1FFE, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (!(dn === 1'b1 && er === 1'b1 && lat == 1)) begin
            n_fail++; $display("FAIL err_edge_load: done=%b err=%b lat=%0d want 1/1/1", dn, er, lat); end
        access(1'b0, 2'b11, 1'b0, 16'h0100, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (dn !== 1'b1 || er !== 1'b1) begin n_fail++; $display("FAIL err_size11: done=%b err=%b want 1/1", dn, er); end
        access(1'b0, 2'b10, 1'b0, 16'h4000, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (dn !== 1'b1 || er !== 1'b1) begin n_fail++; $display("FAIL err_unmapped: done=%b err=%b want 1/1", dn, er); end
        access(1'b1, 2'b01, 1'b0, 16'h7001, 32'h00001234, dn, er, q, lat, bsy);
        n_assert++; if (er !== 1'b1 || ledr !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL err_ledr_misalign: err=%b ledr=%h want 1/CAFEF00D", er, ledr); end
    endtask

    task automatic test_reset_split();
        logic dn, er, bsy; logic [31:0] q; int lat;
        access(1'b1, 2'b10, 1'b0, 16'h0000, 32'h0, dn, er, q, lat, bsy);
        access(1'b1, 2'b10, 1'b0, 16'h0004, 32'h0, dn, er, q, lat, bsy);
        @(negedge i_clk);
        bus.req = 1'b1; bus.wren = 1'b1; bus.size = 2'b10; bus.is_unsigned = 1'b0;
        bus.addr = 16'h0002; bus.st_data = 32'hAABBCCDD;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req = 1'b0;
        n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rsplit_busy: got %b want 1", bus.busy); end
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        n_assert++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rsplit_in_reset: done=%b busy=%b want 0/0", bus.done, bus.busy); end
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        n_assert++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rsplit_no_done: got %b want 0", bus.done); end
        access(1'b0, 2'b10, 1'b0, 16'h0000, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'hCCDD0000) begin n_fail++; $display("FAIL rsplit_word0: got %h want CCDD0000", q); end
        access(1'b0, 2'b10, 1'b0, 16'h0004, 32'h0, dn, er, q, lat, bsy);
        n_assert++; if (q !== 32'h00000000) begin n_fail++; $display("FAIL rsplit_word1: got %h want 00000000", q); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n = 1'b0;
        io_sw = 32'h0; io_btn = 4'h0;
        bus.req = 1'b0; bus.wren = 1'b0; bus.size = 2'b00; bus.is_unsigned = 1'b0;
        bus.addr = 16'h0; bus.st_data = 32'h0;
        test_reset();
        test_aligned();
        test_back_to_back();
        test_misaligned();
        test_io();
        test_sync();
        test_errors();
        test_reset_split();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
